// File: rtl/freq_ctrl_pkg.sv
// Shared types and helpers for the frequency gate controller.
package freq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_GATE  = 2'd2,
    ST_LATCH = 2'd3
  } freq_state_t;

  // Gate counter width; it only has to hold GATE_CYCLES-1.
  function automatic int gate_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/freq_sig_edge_detect.sv
// Rising-edge detector for the measured signal.
// Define FREQ_GATE_SYNC_EN to insert a 2-flop synchronizer ahead of the edge history.
module freq_sig_edge_detect (
  input  logic clk_in,
  input  logic reset_in,
  input  logic sig_in,
  output logic rise_out
);

  logic sig_s;
  logic hist_q, hist_d;

`ifdef FREQ_GATE_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], sig_in};
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) sync_q <= '0;
    else           sync_q <= sync_d;
  end

  assign sig_s = sync_q[1];
`else
  assign sig_s = sig_in;
`endif

  // History follows the signal in every state, so a level that is already high never reads as an edge.
  always_comb begin
    hist_d = sig_s;
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) hist_q <= 1'b0;
    else           hist_q <= hist_d;
  end

  assign rise_out = sig_s & ~hist_q;

endmodule

// File: rtl/freq_gate_controller.sv
// Gated frequency counter controller: clears an external BCD counter, gates
// sig_in rising edges into it for GATE_CYCLES clocks, then latches the result.
// Optional build macro: FREQ_GATE_SYNC_EN (see freq_sig_edge_detect).
//
// state    | meaning
// ST_IDLE  | waiting for start_in
// ST_CLEAR | one cycle counter clear, gate timer load
// ST_GATE  | counting sig_in edges for GATE_CYCLES cycles
// ST_LATCH | final increment settles, result captured on exit
module freq_gate_controller
  import freq_ctrl_pkg::*;
#(
  parameter int DIGITS_NUM  = 6,
  parameter int GATE_CYCLES = 1000000
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    start_in,
  input  logic                    continuous_in,
  input  logic                    sig_in,
  input  logic [4*DIGITS_NUM-1:0] cnt_digits_in,
  input  logic                    cnt_carry_in,
  output logic                    cnt_reset_out,
  output logic                    cnt_enable_out,
  output logic [4*DIGITS_NUM-1:0] result_out,
  output logic                    result_valid_out,
  output logic                    overflow_out,
  output logic                    busy_out
);

  localparam int GW = gate_cnt_width(GATE_CYCLES);

  freq_state_t             state_q, state_d;
  logic [GW-1:0]           gate_cnt_q, gate_cnt_d;
  logic [4*DIGITS_NUM-1:0] result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    ovf_sticky_q, ovf_sticky_d;
  logic                    sig_rise;
  logic                    cnt_enable;

  freq_sig_edge_detect u_edge (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .sig_in   (sig_in),
    .rise_out (sig_rise)
  );

  always_comb begin
    state_d        = state_q;
    gate_cnt_d     = gate_cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    overflow_d     = overflow_q;
    ovf_sticky_d   = ovf_sticky_q;
    cnt_enable     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_in) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        gate_cnt_d   = GW'(GATE_CYCLES - 1);
        ovf_sticky_d = 1'b0;
        state_d      = ST_GATE;
      end
      ST_GATE: begin
        cnt_enable = sig_rise;
        if (sig_rise && cnt_carry_in) ovf_sticky_d = 1'b1;
        if (gate_cnt_q == '0) state_d = ST_LATCH;
        else                  gate_cnt_d = gate_cnt_q - GW'(1);
      end
      ST_LATCH: begin
        result_d       = cnt_digits_in;
        overflow_d     = ovf_sticky_q;
        result_valid_d = 1'b1;
        state_d        = continuous_in ? ST_CLEAR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q        <= ST_IDLE;
      gate_cnt_q     <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
      ovf_sticky_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      gate_cnt_q     <= gate_cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
      ovf_sticky_q   <= ovf_sticky_d;
    end
  end

  // The counter is held clear for as long as reset is applied.
  assign cnt_reset_out    = !reset_in || (state_q == ST_CLEAR);
  assign cnt_enable_out   = cnt_enable;
  assign result_out       = result_q;
  assign result_valid_out = result_valid_q;
  assign overflow_out     = overflow_q;
  assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_freq_gate_controller.sv
// Scoreboard bench for freq_gate_controller: 2-digit BCD counter, 1000-cycle gate.
module tb_freq_gate_controller;

  localparam int DN = 2;
  localparam int GC = 1000;
  localparam int MAXV = 99;

  logic          clk = 1'b0;
  logic          reset_in = 1'b0;
  logic          start_in = 1'b0;
  logic          continuous_in = 1'b0;
  logic          sig_in = 1'b0;
  logic [4*DN-1:0] cnt_digits;
  logic          cnt_carry;
  logic          cnt_reset_out, cnt_enable_out, result_valid_out, overflow_out, busy_out;
  logic [4*DN-1:0] result_out;

  freq_gate_controller #(.DIGITS_NUM(DN), .GATE_CYCLES(GC)) dut (
    .clk_in           (clk),
    .reset_in         (reset_in),
    .start_in         (start_in),
    .continuous_in    (continuous_in),
    .sig_in           (sig_in),
    .cnt_digits_in    (cnt_digits),
    .cnt_carry_in     (cnt_carry),
    .cnt_reset_out    (cnt_reset_out),
    .cnt_enable_out   (cnt_enable_out),
    .result_out       (result_out),
    .result_valid_out (result_valid_out),
    .overflow_out     (overflow_out),
    .busy_out         (busy_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4*DN-1:0] to_bcd(input int v);
    logic [4*DN-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DN; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // External BCD counter the controller drives.
  int cnt_val = 0;
  always @(posedge clk) begin
    if (cnt_reset_out)       cnt_val <= 0;
    else if (cnt_enable_out) cnt_val <= (cnt_val == MAXV) ? 0 : cnt_val + 1;
  end
  assign cnt_digits = to_bcd(cnt_val);
  assign cnt_carry  = (cnt_val == MAXV);

  // Stimulus waveform: square wave (period>0) or constant level.
  int wf_period = 0, wf_phase = 0;
  bit wf_level = 1'b0;

  function automatic bit sig_at(input int k);
    if (wf_period == 0) return wf_level;
    return ((k + wf_phase) % wf_period) < (wf_period / 2);
  endfunction

  always @(negedge clk) sig_in = sig_at(cyc);

  // Reference: rising edges seen during the gate window, cycles t+2 .. t+GC+1.
  function automatic int count_edges(input int t);
    int n = 0;
    for (int k = t + 2; k <= t + GC + 1; k++)
      if (sig_at(k) && !sig_at(k - 1)) n++;
    return n;
  endfunction

  typedef struct {
    logic [4*DN-1:0] res;
    logic            ovf;
    int              at;
    logic            clr;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic exp_t make_exp(input int t, input bit clr);
    exp_t e;
    int n;
    n = count_edges(t);
    e.res = to_bcd(n % (MAXV + 1));
    e.ovf = (n > MAXV);
    e.at  = t + GC + 3;
    e.clr = clr;
    return e;
  endfunction

  always @(negedge clk) begin
    if (result_valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", int'(result_out), int'(e.res));
        chk("overflow", int'(overflow_out), int'(e.ovf));
        chk("strobe_cycle", cyc, e.at);
        chk("cnt_reset_at_strobe", int'(cnt_reset_out), int'(e.clr));
      end
    end
  end

  task automatic set_wave(input int period, input int phase, input bit level);
    @(negedge clk);
    wf_period = period;
    wf_phase  = phase;
    wf_level  = level;
    repeat (3) @(negedge clk);
  endtask

  // Returns the cycle in which start_in was sampled.
  task automatic pulse_start(input bit cont, output int t);
    @(negedge clk);
    start_in      = 1'b1;
    continuous_in = cont;
    t             = cyc;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic measure_once();
    int t;
    pulse_start(1'b0, t);
    sb.push_back(make_exp(t, 1'b0));
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while (sb.size() > 0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() > 0) begin
      chk("strobe_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_result", int'(result_out), 0);
    chk("rst_valid", int'(result_valid_out), 0);
    chk("rst_overflow", int'(overflow_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_cnt_enable", int'(cnt_enable_out), 0);
    chk("rst_cnt_reset", int'(cnt_reset_out), 1);
    reset_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_cnt_reset", int'(cnt_reset_out), 0);

    // Square wave, period 40: 25 edges in the gate.
    set_wave(40, 7, 1'b0);
    measure_once();
    @(negedge clk);
    chk("busy_in_gate", int'(busy_out), 1);
    drain(GC + 20);

    // Held high from before start: no edges.
    set_wave(0, 0, 1'b1);
    measure_once();
    drain(GC + 20);

    // Period 4: 250 edges overflow two digits.
    set_wave(4, 1, 1'b0);
    measure_once();
    drain(GC + 20);

    // Continuous: three back-to-back results.
    set_wave(30, 3, 1'b0);
    pulse_start(1'b1, t);
    for (int n = 0; n < 3; n++)
      sb.push_back(make_exp(t + n * (GC + 2), n < 2));
    repeat (2 * (GC + 2) + 10) @(negedge clk);
    continuous_in = 1'b0;
    drain(2 * GC);

    // Reset mid-gate discards the measurement.
    set_wave(40, 0, 1'b0);
    pulse_start(1'b0, t);
    repeat (50) @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);
    reset_in = 1'b1;
    chk("abort_busy", int'(busy_out), 0);
    chk("abort_result", int'(result_out), 0);
    chk("abort_overflow", int'(overflow_out), 0);
    repeat (GC + 10) @(negedge clk);
    measure_once();
    drain(GC + 20);

    // Start pulsed mid-gate is ignored.
    set_wave(24, 5, 1'b0);
    measure_once();
    repeat (300) @(negedge clk);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    drain(GC + 20);
    repeat (GC + 10) @(negedge clk);

    // Randomized waveforms.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 4) == 0)
        set_wave(0, 0, 1'($urandom_range(0, 1)));
      else
        set_wave(int'($urandom_range(4, 60)), int'($urandom_range(0, 63)), 1'b0);
      measure_once();
      drain(GC + 20);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/freq_gate_controller.md
FREQ_GATE_CONTROLLER -- requirements
Module: freq_gate_controller

Interface
REQ-001 SHALL have parameter DIGITS_NUM, default 6: number of BCD digits in the controlled counter.
REQ-002 SHALL have parameter GATE_CYCLES, default 1000000: gate length in clk_in cycles; legal values are >= 4.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-004 SHALL have port reset_in, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port start_in, input, 1 bit: request one measurement.
REQ-006 SHALL have port continuous_in, input, 1 bit: restart automatically after each result.
REQ-007 SHALL have port sig_in, input, 1 bit: measured signal, asynchronous to clk_in.
REQ-008 SHALL have port cnt_digits_in, input, 4*DIGITS_NUM bits: counter digit value.
REQ-009 SHALL have port cnt_carry_in, input, 1 bit: counter terminal-count carry.
REQ-010 SHALL have port cnt_reset_out, output, 1 bit: active-high clear to the counter.
REQ-011 SHALL have port cnt_enable_out, output, 1 bit: one-cycle count pulse to the counter.
REQ-012 SHALL have port result_out, output, 4*DIGITS_NUM bits: latched BCD result.
REQ-013 SHALL have port result_valid_out, output, 1 bit: one-cycle strobe for a new result.
REQ-014 SHALL have port overflow_out, output, 1 bit: latched result exceeded the counter range.
REQ-015 SHALL have port busy_out, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, CLEAR, GATE and LATCH.
REQ-017 In IDLE with start_in=1, the block SHALL go to CLEAR; in every other state start_in SHALL be ignored.
REQ-018 CLEAR SHALL last exactly 1 cycle with cnt_reset_out=1, then go to GATE; cnt_reset_out SHALL be 0 in all other non-reset cycles.
REQ-019 GATE SHALL last exactly GATE_CYCLES cycles, timed by an internal gate counter that is loaded in CLEAR.
REQ-020 In GATE, cnt_enable_out SHALL be 1 for exactly one cycle per rising edge of the synchronized sig_in; it SHALL be 0 in every other state.
REQ-021 The edge-detect history register SHALL update in every state, so a sig_in level already high on entry to GATE SHALL NOT count as an edge.
REQ-022 The sticky overflow flag SHALL clear in CLEAR and SHALL set in GATE on any cycle with cnt_enable_out=1 and cnt_carry_in=1.
REQ-023 LATCH SHALL last 1 cycle, letting the final gate increment settle; at the clock edge ending LATCH the block SHALL update result_out and overflow_out and set result_valid_out=1 for one cycle.
REQ-024 Latency: if start_in is sampled in cycle t, result_valid_out SHALL be high in cycle t+GATE_CYCLES+3.
REQ-025 After LATCH the next state SHALL be CLEAR if continuous_in=1 (sampled in LATCH), otherwise IDLE.
REQ-026 result_out and overflow_out SHALL hold their values until the next LATCH.
REQ-027 The sig_in maximum frequency SHALL be below clk_in/4; edges above this rate may be missed, which is documented and not flagged.

Reset
REQ-028 reset_in=0 at a clock edge SHALL force IDLE in any state, including mid-GATE, and discard any partial measurement.
REQ-029 Reset values SHALL be: result_out=0, result_valid_out=0, overflow_out=0, busy_out=0, cnt_enable_out=0, cnt_reset_out=1.
REQ-030 Reset values SHALL also be: the gate counter, the synchronizer flops and the edge history all at 0.

Configuration
REQ-031 With macro FREQ_GATE_SYNC_EN defined, sig_in SHALL pass through a 2-flop synchronizer before edge detection, adding 2 cycles of edge latency.
REQ-032 Without FREQ_GATE_SYNC_EN, sig_in SHALL feed the edge-detect register directly; this is for synchronous test stimulus only.

Structure
REQ-033 Package freq_ctrl_pkg SHALL hold the state enum type freq_state_t and a width helper for the gate counter, $clog2(GATE_CYCLES).
REQ-034 Synchronization and rising-edge detection SHALL be one sub-module, freq_sig_edge_detect; the FSM, gate counter and result registers SHALL stay in freq_gate_controller.

Verification
REQ-035 GATE_CYCLES=100, square wave period 10 clk, single start -> result_out=0x000010, overflow_out=0, one valid strobe at t+103.
REQ-036 sig_in held high from before start, no edges -> result_out=0x000000.
REQ-037 DIGITS_NUM=2, GATE_CYCLES=1000, sig period 4 (250 edges) -> overflow_out=1.
REQ-038 continuous_in=1 for 3 results -> valid strobes exactly GATE_CYCLES+2 cycles apart, with cnt_reset_out pulsed before each gate.
REQ-039 reset_in=0 at gate cycle 50 -> IDLE, result_out=0, no strobe; a new start then gives a correct result.
REQ-040 start_in pulsed during GATE -> ignored; exactly one result strobe.
